// File: rtl/core_pkg.sv
// Shared definitions for the core input buffer: state encodings, default
// geometry and an address range helper used by both control and storage.
package core_pkg;

   // Buffer geometry: 64 RGB pixels, filled by 32-bit beats
   localparam int DEPTH  = 192;
   localparam int WORDS  = 48;
   localparam int PIXELS = 64;

   // Buffer control states
   typedef enum logic [1:0] {
      EMPTY = 2'h0,
      FILL  = 2'h1,
      DRAIN = 2'h2
   } state_t;

   // True when a byte address falls inside a buffer of 'depth' bytes
   function automatic logic addr_ok(input logic [7:0] addr, input int depth);
      return ({1'b0, addr} < 9'(depth));
   endfunction

endpackage

// File: rtl/core_in_buf_if.sv
// Bus bundle for the core input buffer: one 4-lane write strobe group, one
// 3-byte pixel read strobe group and the registered read/status outputs.
//
// Handshake: I_WR_EN and I_RD_EN are single-cycle strobes with no ready
// back-pressure. A strobe is accepted only in the state that allows it
// (write in EMPTY/FILL, read in DRAIN); otherwise it is ignored. An accepted
// read returns O_R/O_G/O_B with O_RVALID high for exactly the next cycle.
interface core_in_buf_if;
   logic        I_WR_EN;
   logic [31:0] I_WDATA;
   logic [7:0]  I_ADDR0;
   logic [7:0]  I_ADDR1;
   logic [7:0]  I_ADDR2;
   logic [7:0]  I_ADDR3;
   logic        I_RD_EN;
   logic [7:0]  I_ADDRR;
   logic [7:0]  I_ADDRG;
   logic [7:0]  I_ADDRB;
   logic [7:0]  O_R;
   logic [7:0]  O_G;
   logic [7:0]  O_B;
   logic        O_RVALID;
   logic        O_FULL;
   logic        O_EMPTY;
   logic        O_ERR;

   // Bus side that issues writes and reads
   modport master (
      output I_WR_EN, I_WDATA, I_ADDR0, I_ADDR1, I_ADDR2, I_ADDR3,
      output I_RD_EN, I_ADDRR, I_ADDRG, I_ADDRB,
      input  O_R, O_G, O_B, O_RVALID, O_FULL, O_EMPTY, O_ERR
   );

   // Buffer side
   modport slave (
      input  I_WR_EN, I_WDATA, I_ADDR0, I_ADDR1, I_ADDR2, I_ADDR3,
      input  I_RD_EN, I_ADDRR, I_ADDRG, I_ADDRB,
      output O_R, O_G, O_B, O_RVALID, O_FULL, O_EMPTY, O_ERR
   );
endinterface

// File: rtl/core_buf_ram.sv
// Byte-wide storage for the core input buffer: four write lanes, three
// registered read lanes. The array itself is never reset; only the read
// data registers clear so the outputs start at zero.
module core_buf_ram
   import core_pkg::*;
#(
   parameter int DEPTH = core_pkg::DEPTH
) (
   input  logic            clk,
   input  logic            rd_clr,
   input  logic [3:0]      we,
   input  logic [3:0][7:0] waddr,
   input  logic [3:0][7:0] wdata,
   input  logic            re,
   input  logic [2:0][7:0] raddr,
   output logic [2:0][7:0] rdata
);

   logic [7:0]      mem [DEPTH];
   logic [2:0][7:0] rdata_d;
   logic [2:0][7:0] rdata_q;

   // Store each enabled lane; the upper lane wins if two lanes share an address
   always_ff @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (we[k]) begin
            mem[waddr[k]] <= wdata[k];
         end
      end
   end

   // Look up the three read bytes; out-of-range bytes read as zero, idle cycles hold
   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         for (int k = 0; k < 3; k++) begin
            rdata_d[k] = addr_ok(raddr[k], DEPTH) ? mem[raddr[k]] : 8'h00;
         end
      end
   end

   // Read data register with synchronous clear
   always_ff @(posedge clk) begin
      if (rd_clr) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/core_in_buf.sv
// Core input buffer: a DEPTH-byte ping buffer filled by WORDS 32-bit beats
// and drained by PIXELS 3-byte RGB reads. Control is a three-state machine
// (EMPTY -> FILL -> DRAIN -> EMPTY) with a write and a read beat counter.
//
// Optional feature macro CORE_IN_BUF_ERR_EN: when defined, O_ERR is a sticky
// flag set by any ignored strobe or out-of-range byte address and cleared only
// by reset. When undefined, O_ERR is tied low and no error logic exists.
module core_in_buf
   import core_pkg::*;
#(
   parameter int DEPTH  = core_pkg::DEPTH,
   parameter int WORDS  = core_pkg::WORDS,
   parameter int PIXELS = core_pkg::PIXELS
) (
   input  logic         I_HCLK,
   input  logic         I_HRESET_N,
   core_in_buf_if.slave bus,
   output state_t       dbg_state
);

   localparam logic [5:0] WR_LAST = 6'(WORDS - 1);
   localparam logic [5:0] RD_LAST = 6'(PIXELS - 1);

   state_t          state_d, state_q;
   logic [5:0]      wr_cnt_d, wr_cnt_q;
   logic [5:0]      rd_cnt_d, rd_cnt_q;
   logic            rvalid_d, rvalid_q;
   logic            full_d, full_q;
   logic            empty_d, empty_q;
   logic            wr_acc;
   logic            rd_acc;
   logic [3:0]      lane_we;
   logic [3:0][7:0] waddr;
   logic [2:0][7:0] raddr;
   logic [2:0][7:0] rdata;

   // A strobe acts only in the state that allows it
   assign wr_acc = bus.I_WR_EN && ((state_q == EMPTY) || (state_q == FILL));
   assign rd_acc = bus.I_RD_EN && (state_q == DRAIN);

   assign waddr = {bus.I_ADDR3, bus.I_ADDR2, bus.I_ADDR1, bus.I_ADDR0};
   assign raddr = {bus.I_ADDRB, bus.I_ADDRG, bus.I_ADDRR};

   // Per-lane write enables: out-of-range lanes are dropped, the beat still counts
   always_comb begin
      lane_we = '0;
      for (int k = 0; k < 4; k++) begin
         lane_we[k] = wr_acc && addr_ok(waddr[k], DEPTH);
      end
   end

   // Next state, beat counters and registered status flags
   always_comb begin
      state_d  = state_q;
      wr_cnt_d = wr_cnt_q;
      rd_cnt_d = rd_cnt_q;
      case (state_q)
         EMPTY, FILL: begin
            if (wr_acc) begin
               if (wr_cnt_q == WR_LAST) begin
                  state_d  = DRAIN;
                  wr_cnt_d = '0;
               end else begin
                  state_d  = FILL;
                  wr_cnt_d = wr_cnt_q + 6'd1;
               end
            end
         end
         DRAIN: begin
            if (rd_acc) begin
               if (rd_cnt_q == RD_LAST) begin
                  state_d  = EMPTY;
                  rd_cnt_d = '0;
               end else begin
                  rd_cnt_d = rd_cnt_q + 6'd1;
               end
            end
         end
         default: begin
            state_d  = EMPTY;
            wr_cnt_d = '0;
            rd_cnt_d = '0;
         end
      endcase
      rvalid_d = rd_acc;
      full_d   = (state_d == DRAIN);
      empty_d  = (state_d == EMPTY);
   end

   // Control registers
   always_ff @(posedge I_HCLK) begin
      if (!I_HRESET_N) begin
         state_q  <= EMPTY;
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
         rvalid_q <= 1'b0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         wr_cnt_q <= wr_cnt_d;
         rd_cnt_q <= rd_cnt_d;
         rvalid_q <= rvalid_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

`ifdef CORE_IN_BUF_ERR_EN
   logic err_d, err_q;

   // Sticky error: ignored strobes or any out-of-range byte of an accepted access
   always_comb begin
      err_d = err_q;
      if (bus.I_WR_EN && (state_q == DRAIN)) begin
         err_d = 1'b1;
      end
      if (bus.I_RD_EN && (state_q != DRAIN)) begin
         err_d = 1'b1;
      end
      for (int k = 0; k < 4; k++) begin
         if (wr_acc && !addr_ok(waddr[k], DEPTH)) begin
            err_d = 1'b1;
         end
      end
      for (int k = 0; k < 3; k++) begin
         if (rd_acc && !addr_ok(raddr[k], DEPTH)) begin
            err_d = 1'b1;
         end
      end
   end

   // Error flag register, cleared only by reset
   always_ff @(posedge I_HCLK) begin
      if (!I_HRESET_N) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign bus.O_ERR = err_q;
`else
   assign bus.O_ERR = 1'b0;
`endif

   core_buf_ram #(
      .DEPTH(DEPTH)
   ) u_ram (
      .clk   (I_HCLK),
      .rd_clr(!I_HRESET_N),
      .we    (lane_we),
      .waddr (waddr),
      .wdata (bus.I_WDATA),
      .re    (rd_acc),
      .raddr (raddr),
      .rdata (rdata)
   );

   assign bus.O_R      = rdata[0];
   assign bus.O_G      = rdata[1];
   assign bus.O_B      = rdata[2];
   assign bus.O_RVALID = rvalid_q;
   assign bus.O_FULL   = full_q;
   assign bus.O_EMPTY  = empty_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_core_in_buf.sv
// Bench for core_in_buf: directed fill/drain sequences with illegal strobes,
// out-of-range lanes and mid-fill reset; read data checked by a scoreboard.
module tb_core_in_buf;
   import core_pkg::*;

   logic   clk = 1'b0;
   logic   rst_n = 1'b0;
   state_t dbg_state;

   core_in_buf_if bus ();

   core_in_buf dut (
      .I_HCLK    (clk),
      .I_HRESET_N(rst_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // Clock
   always #5 clk = ~clk;

   logic [23:0] exp_q[$];
   logic [7:0]  mem_m [0:255];
   logic        exp_err = 1'b0;
   int          n_cmp = 0;
   int          n_bad = 0;

   function automatic logic [7:0] model_rd(input logic [7:0] a);
      return (a < 8'd192) ? mem_m[a] : 8'h00;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every valid read beat must match the oldest expected pixel
   always @(negedge clk) begin
      if (bus.O_RVALID === 1'b1) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_rvalid: got %0h expected no read data",
                     {bus.O_R, bus.O_G, bus.O_B});
         end else begin
            logic [23:0] e;
            e = exp_q.pop_front();
            if ({bus.O_R, bus.O_G, bus.O_B} !== e) begin
               n_bad++;
               $display("FAIL rd_data: got %0h expected %0h", {bus.O_R, bus.O_G, bus.O_B}, e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.I_WR_EN = 1'b0;
      bus.I_WDATA = '0;
      bus.I_ADDR0 = '0;
      bus.I_ADDR1 = '0;
      bus.I_ADDR2 = '0;
      bus.I_ADDR3 = '0;
      bus.I_RD_EN = 1'b0;
      bus.I_ADDRR = '0;
      bus.I_ADDRG = '0;
      bus.I_ADDRB = '0;
   endtask

   // One write beat; 'legal' says whether the bench expects it to store
   task automatic wr_beat(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                          input logic [7:0] a3, input logic [31:0] d, input logic legal,
                          input logic also_rd);
      logic [7:0] a [4];
      a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
      bus.I_WR_EN = 1'b1;
      bus.I_WDATA = d;
      bus.I_ADDR0 = a0;
      bus.I_ADDR1 = a1;
      bus.I_ADDR2 = a2;
      bus.I_ADDR3 = a3;
      bus.I_RD_EN = also_rd;
      if (legal) begin
         for (int k = 0; k < 4; k++) begin
            if (a[k] < 8'd192) mem_m[a[k]] = d[8*k +: 8];
         end
      end
      tick();
      bus.I_WR_EN = 1'b0;
      bus.I_RD_EN = 1'b0;
   endtask

   // One pixel read; a legal read queues its expected bytes
   task automatic rd_px(input logic [7:0] ar, input logic [7:0] ag, input logic [7:0] ab,
                        input logic legal);
      bus.I_RD_EN = 1'b1;
      bus.I_ADDRR = ar;
      bus.I_ADDRG = ag;
      bus.I_ADDRB = ab;
      if (legal) exp_q.push_back({model_rd(ar), model_rd(ag), model_rd(ab)});
      tick();
      bus.I_RD_EN = 1'b0;
   endtask

   // Watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;
      idle();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;

      check("rst_empty", bus.O_EMPTY, 1);
      check("rst_full", bus.O_FULL, 0);
      check("rst_rvalid", bus.O_RVALID, 0);
      check("rst_rgb", {bus.O_R, bus.O_G, bus.O_B}, 0);
      check("rst_err", bus.O_ERR, 0);
      check("rst_state", dbg_state, EMPTY);

      // Aborted fill: 20 beats to 80.., then reset mid-fill
      for (int n = 0; n < 20; n++) begin
         b = 8'(80 + 4 * n);
         wr_beat(b, b + 8'd1, b + 8'd2, b + 8'd3, {4{8'(8'hA0 + n)}}, 1'b1, 1'b0);
         if (n == 0) check("abort_empty_falls", bus.O_EMPTY, 0);
      end
      check("abort_state_fill", dbg_state, FILL);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("midrst_empty", bus.O_EMPTY, 1);
      check("midrst_state", dbg_state, EMPTY);
      check("midrst_full", bus.O_FULL, 0);

      // Full fill: 48 beats of {n,n,n,n} at 4n..4n+3
      for (int n = 0; n < 48; n++) begin
         b = 8'(4 * n);
         if (n == 10) begin
            rd_px(8'd0, 8'd1, 8'd2, 1'b0);
            check("rd_in_fill_rvalid", bus.O_RVALID, 0);
`ifdef CORE_IN_BUF_ERR_EN
            exp_err = 1'b1;
`endif
            check("rd_in_fill_err", bus.O_ERR, exp_err);
         end
         if (n == 30)
            wr_beat(b, b + 8'd1, b + 8'd2, 8'hC0, {4{8'(n)}}, 1'b1, 1'b0);
         else
            wr_beat(b, b + 8'd1, b + 8'd2, b + 8'd3, {4{8'(n)}}, 1'b1, n == 20);
         if (n == 0) begin
            check("fill_empty_falls", bus.O_EMPTY, 0);
            check("fill_state", dbg_state, FILL);
         end
         if (n == 20) check("both_strobes_rvalid", bus.O_RVALID, 0);
         if (n == 46) check("full_before_last", bus.O_FULL, 0);
      end
      check("fill_full", bus.O_FULL, 1);
      check("fill_not_empty", bus.O_EMPTY, 0);
      check("fill_state_drain", dbg_state, DRAIN);

      // Ignored write in DRAIN must not disturb the stored bytes
      wr_beat(8'd0, 8'd1, 8'd2, 8'd3, 32'hFFFF_FFFF, 1'b0, 1'b0);
      check("wr_in_drain_full", bus.O_FULL, 1);

      // Drain 64 pixels; pixel 5 uses an out-of-range blue address
      for (int p = 0; p < 64; p++) begin
         b = 8'(3 * p);
         if (p == 63) begin
            bus.I_WR_EN = 1'b1;
            bus.I_WDATA = 32'h5555_5555;
            bus.I_ADDR0 = 8'd0;
            bus.I_ADDR1 = 8'd1;
            bus.I_ADDR2 = 8'd2;
            bus.I_ADDR3 = 8'd3;
         end
         rd_px(b, b + 8'd1, (p == 5) ? 8'hC5 : b + 8'd2, 1'b1);
         bus.I_WR_EN = 1'b0;
         if (p == 62) check("drain_not_empty", bus.O_EMPTY, 0);
      end
      check("last_rd_empty", bus.O_EMPTY, 1);
      check("last_rd_rvalid", bus.O_RVALID, 1);
      check("last_rd_full", bus.O_FULL, 0);
      tick();
      check("post_drain_state", dbg_state, EMPTY);
      check("post_drain_empty", bus.O_EMPTY, 1);

      // Ignored read in EMPTY: outputs hold the last pixel (R at 189 -> 8'h2F)
      rd_px(8'd0, 8'd1, 8'd2, 1'b0);
      check("rd_in_empty_rvalid", bus.O_RVALID, 0);
      check("rd_in_empty_hold_r", bus.O_R, 8'h2F);
      tick();
      tick();
      check("final_err", bus.O_ERR, exp_err);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
